lsu_mem_ctrl: RTL and testbench

Load/store initiator that sits between the execute stage and the byte-addressable data memory. It accepts one load or store request per transaction over a valid/ready handshake and drives the memory port (addr, data, read_en, write_en, funct3). The memory port has a combinational read and a posedge write. Aligned accesses complete in a single memory cycle. Misaligned halfword and word accesses are split into sequential byte accesses, and the load result is reassembled and sign-extended per funct3.

---
 rtl/lsu_mem_ctrl_pkg.sv | 59 +++++
 rtl/lsu_load_extend.sv | 29 ++
 rtl/lsu_mem_ctrl.sv | 152 +++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl_pkg
// Brief    : Shared types, funct3 constants and size/alignment helpers for
//            the load/store memory controller.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_mem_ctrl_pkg;

   // RISC-V load/store funct3 encodings used by the controller
   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;
   localparam logic [2:0] FUNCT3_SB  = 3'b000;

   typedef enum logic [1:0] {
      LSU_IDLE   = 2'd0,
      LSU_ACCESS = 2'd1,
      LSU_SPLIT  = 2'd2,
      LSU_RESP   = 2'd3
   } lsu_state_t;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } lsu_size_t;

   // Reserved encodings fall back to word, as the memory does
   function automatic lsu_size_t funct3_to_size(input logic [2:0] f3);
      lsu_size_t sz;
      case (f3)
         FUNCT3_LB, FUNCT3_LBU: sz = SIZE_BYTE;
         FUNCT3_LH, FUNCT3_LHU: sz = SIZE_HALF;
         FUNCT3_LW:             sz = SIZE_WORD;
         default:               sz = SIZE_WORD;
      endcase
      return sz;
   endfunction

   function automatic logic is_aligned(input lsu_size_t sz, input logic [1:0] a);
      logic ok;
      case (sz)
         SIZE_BYTE: ok = 1'b1;
         SIZE_HALF: ok = (a[0] == 1'b0);
         default:   ok = (a == 2'b00);
      endcase
      return ok;
   endfunction

   // Index of the final byte op of a split access (half: 2 ops, word: 4 ops)
   function automatic logic [1:0] split_last_idx(input lsu_size_t sz);
      return (sz == SIZE_HALF) ? 2'd1 : 2'd3;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_extend.sv
`default_nettype none
// ============================================================================
// Module   : lsu_load_extend
// Brief    : Combinational sign/zero extension of an assembled load value
//            according to the load funct3.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_load_extend
   import lsu_mem_ctrl_pkg::*;
(
   input  logic [31:0] bytes_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   // Select extension from funct3; only LB/LH sign-extend
   always_comb begin
      data_o = bytes_i;
      case (funct3_i)
         FUNCT3_LB:  data_o = {{24{bytes_i[7]}}, bytes_i[7:0]};
         FUNCT3_LH:  data_o = {{16{bytes_i[15]}}, bytes_i[15:0]};
         FUNCT3_LBU: data_o = {24'h0, bytes_i[7:0]};
         FUNCT3_LHU: data_o = {16'h0, bytes_i[15:0]};
         default:    data_o = bytes_i;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Brief    : Load/store initiator between execute stage and a byte-addressed
//            data memory. Aligned accesses take one memory cycle; misaligned
//            half/word accesses are split into byte ops (or rejected).
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl
   import lsu_mem_ctrl_pkg::*;
#(
   parameter int AWIDTH           = 32,
   parameter int DWIDTH           = 32,
   parameter int SPLIT_MISALIGNED = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [AWIDTH-1:0] req_addr_i,
   input  logic [DWIDTH-1:0] req_wdata_i,
   input  logic              req_we_i,
   input  logic [2:0]        req_funct3_i,
   output logic              rsp_valid_o,
   output logic [DWIDTH-1:0] rsp_rdata_o,
   output logic              rsp_misaligned_o,
   output logic              rsp_err_o,
   output logic [AWIDTH-1:0] mem_addr_o,
   output logic [DWIDTH-1:0] mem_data_o,
   output logic              mem_read_en_o,
   output logic              mem_write_en_o,
   output logic [2:0]        mem_funct3_o,
   input  logic [DWIDTH-1:0] mem_data_i
);

   lsu_state_t        state_q, state_d;
   logic [AWIDTH-1:0] addr_q;
   logic [DWIDTH-1:0] wdata_q;
   logic              we_q;
   logic [2:0]        funct3_q;
   logic [1:0]        idx_q;
   logic [DWIDTH-1:0] rdata_q;   // aligned: extended result; split: assembled bytes
   logic              split_q;
   logic              err_q;

   logic              req_aligned;
   logic [1:0]        last_idx;
   logic [DWIDTH-1:0] split_ext;

   assign req_aligned = is_aligned(funct3_to_size(req_funct3_i), req_addr_i[1:0]);
   assign last_idx    = split_last_idx(funct3_to_size(funct3_q));

   lsu_load_extend u_extend (
      .bytes_i  (rdata_q),
      .funct3_i (funct3_q),
      .data_o   (split_ext)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= LSU_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and combinational decode of the request/response/memory ports
   always_comb begin
      state_d          = state_q;
      req_ready_o      = 1'b0;
      rsp_valid_o      = 1'b0;
      rsp_rdata_o      = '0;
      rsp_misaligned_o = 1'b0;
      rsp_err_o        = 1'b0;
      mem_addr_o       = '0;
      mem_data_o       = '0;
      mem_read_en_o    = 1'b0;
      mem_write_en_o   = 1'b0;
      mem_funct3_o     = 3'b000;
      case (state_q)
         LSU_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               if (req_aligned)                state_d = LSU_ACCESS;
               else if (SPLIT_MISALIGNED != 0) state_d = LSU_SPLIT;
               else                            state_d = LSU_RESP;
            end
         end
         LSU_ACCESS: begin
            mem_addr_o     = addr_q;
            mem_funct3_o   = funct3_q;
            mem_data_o     = wdata_q;
            mem_read_en_o  = !we_q;
            mem_write_en_o = we_q;
            state_d        = LSU_RESP;
         end
         LSU_SPLIT: begin
            mem_addr_o     = addr_q + AWIDTH'(idx_q);
            mem_funct3_o   = we_q ? FUNCT3_SB : FUNCT3_LBU;
            mem_data_o     = {{(DWIDTH-8){1'b0}}, wdata_q[{idx_q, 3'b000} +: 8]};
            mem_read_en_o  = !we_q;
            mem_write_en_o = we_q;
            if (idx_q == last_idx) state_d = LSU_RESP;
         end
         LSU_RESP: begin
            rsp_valid_o      = 1'b1;
            rsp_misaligned_o = split_q;
            rsp_err_o        = err_q;
            if (!we_q && !err_q) rsp_rdata_o = split_q ? split_ext : rdata_q;
            state_d          = LSU_IDLE;
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   // Capture request, collect load data, step the split byte index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         idx_q    <= 2'd0;
         rdata_q  <= '0;
         split_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            LSU_IDLE: begin
               if (req_valid_i) begin
                  addr_q   <= req_addr_i;
                  wdata_q  <= req_wdata_i;
                  we_q     <= req_we_i;
                  funct3_q <= req_funct3_i;
                  idx_q    <= 2'd0;
                  rdata_q  <= '0;
                  split_q  <= !req_aligned && (SPLIT_MISALIGNED != 0);
                  err_q    <= !req_aligned && (SPLIT_MISALIGNED == 0);
               end
            end
            LSU_ACCESS: begin
               if (!we_q) rdata_q <= mem_data_i;
            end
            LSU_SPLIT: begin
               if (!we_q) rdata_q[{idx_q, 3'b000} +: 8] <= mem_data_i[7:0];
               idx_q <= idx_q + 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_ctrl
// Brief    : Directed self-checking bench for lsu_mem_ctrl with a byte
//            memory model (combinational read, posedge write).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_we;
   logic [2:0]  req_f3;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_mis;
   logic        rsp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_re;
   logic        mem_we;
   logic [2:0]  mem_f3;
   logic [31:0] mem_rdata;

   // Second instance with splitting disabled
   logic        n_req_valid;
   logic        n_req_ready;
   logic [31:0] n_req_addr;
   logic        n_rsp_valid;
   logic [31:0] n_rsp_rdata;
   logic        n_rsp_mis;
   logic        n_rsp_err;
   logic [31:0] n_mem_addr;
   logic [31:0] n_mem_wdata;
   logic        n_mem_re;
   logic        n_mem_we;
   logic [2:0]  n_mem_f3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lsu_mem_ctrl #(.AWIDTH(32), .DWIDTH(32), .SPLIT_MISALIGNED(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .req_we_i(req_we), .req_funct3_i(req_f3),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
      .rsp_misaligned_o(rsp_mis), .rsp_err_o(rsp_err),
      .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_read_en_o(mem_re),
      .mem_write_en_o(mem_we), .mem_funct3_o(mem_f3), .mem_data_i(mem_rdata)
   );

   lsu_mem_ctrl #(.AWIDTH(32), .DWIDTH(32), .SPLIT_MISALIGNED(0)) dut_nosplit (
      .clk(clk), .rst(rst),
      .req_valid_i(n_req_valid), .req_ready_o(n_req_ready), .req_addr_i(n_req_addr),
      .req_wdata_i(32'h1234_5678), .req_we_i(1'b0), .req_funct3_i(3'b010),
      .rsp_valid_o(n_rsp_valid), .rsp_rdata_o(n_rsp_rdata),
      .rsp_misaligned_o(n_rsp_mis), .rsp_err_o(n_rsp_err),
      .mem_addr_o(n_mem_addr), .mem_data_o(n_mem_wdata), .mem_read_en_o(n_mem_re),
      .mem_write_en_o(n_mem_we), .mem_funct3_o(n_mem_f3), .mem_data_i(32'hFFFF_FFFF)
   );

   // ---------------- memory model: 1 KiB window on addr[9:0] ----------------
   logic [7:0] mem [0:1023];
   logic       mem_clear;
   logic [9:0] ma;
   logic [7:0] b0, b1, b2, b3;

   always_comb begin
      ma = mem_addr[9:0];
      b0 = mem[ma];
      b1 = mem[ma + 10'd1];
      b2 = mem[ma + 10'd2];
      b3 = mem[ma + 10'd3];
      case (mem_f3)
         3'b000:  mem_rdata = {{24{b0[7]}}, b0};
         3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
         3'b100:  mem_rdata = {24'h0, b0};
         3'b101:  mem_rdata = {16'h0, b1, b0};
         default: mem_rdata = {b3, b2, b1, b0};
      endcase
   end

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      end else if (mem_we) begin
         mem[ma] <= mem_wdata[7:0];
         if (mem_f3[1:0] != 2'b00) mem[ma + 10'd1] <= mem_wdata[15:8];
         if (mem_f3[1:0] != 2'b00 && mem_f3[1:0] != 2'b01) begin
            mem[ma + 10'd2] <= mem_wdata[23:16];
            mem[ma + 10'd3] <= mem_wdata[31:24];
         end
      end
   end

   // ---------------- transaction recorder ----------------
   int          lat, n_wr, n_rd;
   logic [31:0] o_rdata;
   logic        o_mis, o_err;
   logic [31:0] wr_addr [0:7];
   logic [31:0] wr_data [0:7];
   logic [2:0]  wr_f3   [0:7];
   logic [31:0] rd_addr [0:7];
   logic [2:0]  rd_f3   [0:7];

   // lat = k+1 where the response is seen k edges after the accept edge
   task automatic do_req(input logic [31:0] a, input logic [31:0] wd,
                         input logic we, input logic [2:0] f3);
      @(negedge clk);
      for (int w = 0; w < 6 && !req_ready; w++) @(negedge clk);
      req_addr = a; req_wdata = wd; req_we = we; req_f3 = f3; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0; n_wr = 0; n_rd = 0; o_rdata = 32'hx; o_mis = 1'bx; o_err = 1'bx;
      for (int k = 0; k < 10; k++) begin
         if (rsp_valid) begin
            lat = k + 1; o_rdata = rsp_rdata; o_mis = rsp_mis; o_err = rsp_err;
            break;
         end
         if (mem_we) begin
            if (n_wr < 8) begin
               wr_addr[n_wr] = mem_addr; wr_data[n_wr] = mem_wdata; wr_f3[n_wr] = mem_f3;
            end
            n_wr++;
         end
         if (mem_re) begin
            if (n_rd < 8) begin
               rd_addr[n_rd] = mem_addr; rd_f3[n_rd] = mem_f3;
            end
            n_rd++;
         end
         @(posedge clk); #1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; n_req_valid = 1'b0;
      req_addr = '0; req_wdata = '0; req_we = 1'b0; req_f3 = 3'b000; n_req_addr = '0;
      mem_clear = 1'b1;
      #1;
      checks++;
      if ({rsp_valid, rsp_rdata, rsp_mis, rsp_err} !== 35'h0) begin
         errors++; $display("FAIL reset_rsp: got %h required 0", {rsp_valid, rsp_rdata, rsp_mis, rsp_err});
      end
      checks++;
      if ({mem_addr, mem_wdata, mem_re, mem_we, mem_f3} !== 69'h0) begin
         errors++; $display("FAIL reset_mem: got %h required 0", {mem_addr, mem_wdata, mem_re, mem_we, mem_f3});
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b required 1", req_ready);
      end
      repeat (2) @(posedge clk);
      #1; mem_clear = 1'b0; rst = 1'b0;
   endtask

   task automatic test_aligned_word();
      do_req(32'h0100_0100, 32'hDEAD_BEEF, 1'b1, 3'b010);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d required 2", lat); end
      checks++;
      if (n_wr !== 1 || n_rd !== 0) begin
         errors++; $display("FAIL sw_cycles: got wr=%0d rd=%0d required wr=1 rd=0", n_wr, n_rd);
      end
      checks++;
      if ({wr_addr[0], wr_data[0], wr_f3[0]} !== {32'h0100_0100, 32'hDEAD_BEEF, 3'b010}) begin
         errors++; $display("FAIL sw_port: got a=%h d=%h f3=%b required a=01000100 d=deadbeef f3=010",
                            wr_addr[0], wr_data[0], wr_f3[0]);
      end
      checks++;
      if ({o_rdata, o_mis, o_err} !== 34'h0) begin
         errors++; $display("FAIL sw_rsp: got rdata=%h mis=%b err=%b required 0/0/0", o_rdata, o_mis, o_err);
      end
      do_req(32'h0100_0100, 32'h0, 1'b0, 3'b010);
      checks++;
      if (lat !== 2 || n_rd !== 1 || n_wr !== 0) begin
         errors++; $display("FAIL lw_timing: got lat=%0d rd=%0d wr=%0d required 2/1/0", lat, n_rd, n_wr);
      end
      checks++;
      if (o_rdata !== 32'hDEAD_BEEF || o_mis !== 1'b0) begin
         errors++; $display("FAIL lw_data: got %h mis=%b required deadbeef mis=0", o_rdata, o_mis);
      end
   endtask

   task automatic test_aligned_sub();
      do_req(32'h0100_0103, 32'h0, 1'b0, 3'b000);
      checks++;
      if (o_rdata !== 32'hFFFF_FFDE || lat !== 2) begin
         errors++; $display("FAIL lb: got %h lat=%0d required ffffffde lat=2", o_rdata, lat);
      end
      do_req(32'h0100_0103, 32'h0, 1'b0, 3'b100);
      checks++;
      if (o_rdata !== 32'h0000_00DE) begin
         errors++; $display("FAIL lbu: got %h required 000000de", o_rdata);
      end
      do_req(32'h0100_0102, 32'h0, 1'b0, 3'b101);
      checks++;
      if (o_rdata !== 32'h0000_DEAD || o_mis !== 1'b0) begin
         errors++; $display("FAIL lhu: got %h mis=%b required 0000dead mis=0", o_rdata, o_mis);
      end
   endtask

   task automatic test_split_word_load();
      do_req(32'h0100_0104, 32'h1122_3344, 1'b1, 3'b010);
      do_req(32'h0100_0101, 32'h0, 1'b0, 3'b010);
      checks++;
      if (lat !== 5 || n_rd !== 4 || n_wr !== 0) begin
         errors++; $display("FAIL split_lw_timing: got lat=%0d rd=%0d wr=%0d required 5/4/0", lat, n_rd, n_wr);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rd_addr[i] !== 32'h0100_0101 + i || rd_f3[i] !== 3'b100) begin
            errors++; $display("FAIL split_lw_op%0d: got a=%h f3=%b required a=%h f3=100",
                               i, rd_addr[i], rd_f3[i], 32'h0100_0101 + i);
         end
      end
      checks++;
      if (o_rdata !== 32'h44DE_ADBE || o_mis !== 1'b1 || o_err !== 1'b0) begin
         errors++; $display("FAIL split_lw_data: got %h mis=%b err=%b required 44deadbe mis=1 err=0",
                            o_rdata, o_mis, o_err);
      end
   endtask

   task automatic test_split_half();
      do_req(32'h0100_0201, 32'h0000_A55A, 1'b1, 3'b001);
      checks++;
      if (lat !== 3 || n_wr !== 2 || o_mis !== 1'b1) begin
         errors++; $display("FAIL split_sh_timing: got lat=%0d wr=%0d mis=%b required 3/2/1", lat, n_wr, o_mis);
      end
      checks++;
      if ({wr_addr[0], wr_data[0], wr_f3[0]} !== {32'h0100_0201, 32'h0000_005A, 3'b000} ||
          {wr_addr[1], wr_data[1], wr_f3[1]} !== {32'h0100_0202, 32'h0000_00A5, 3'b000}) begin
         errors++; $display("FAIL split_sh_ops: got %h/%h/%b %h/%h/%b required 01000201/5a/000 01000202/a5/000",
                            wr_addr[0], wr_data[0], wr_f3[0], wr_addr[1], wr_data[1], wr_f3[1]);
      end
      do_req(32'h0100_0201, 32'h0, 1'b0, 3'b001);
      checks++;
      if (o_rdata !== 32'hFFFF_A55A || lat !== 3) begin
         errors++; $display("FAIL split_lh: got %h lat=%0d required ffffa55a lat=3", o_rdata, lat);
      end
   endtask

   task automatic test_reset_mid_split();
      int seen_rsp = 0;
      int seen_wr  = 0;
      @(negedge clk);
      for (int w = 0; w < 6 && !req_ready; w++) @(negedge clk);
      req_addr = 32'h0100_0301; req_wdata = 32'hCAFE_BABE; req_we = 1'b1; req_f3 = 3'b010;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h0100_0301) begin
         errors++; $display("FAIL abort_first_byte: got we=%b a=%h required we=1 a=01000301", mem_we, mem_addr);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if (mem_we !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL abort_drop: got we=%b rsp=%b required 0/0", mem_we, rsp_valid);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (rsp_valid) seen_rsp++;
         if (mem_we) seen_wr++;
         @(posedge clk); #1;
      end
      checks++;
      if (req_ready !== 1'b1 || seen_rsp !== 0 || seen_wr !== 0) begin
         errors++; $display("FAIL abort_after: got ready=%b rsp=%0d wr=%0d required 1/0/0",
                            req_ready, seen_rsp, seen_wr);
      end
      checks++;
      if ({mem[10'h300], mem[10'h301], mem[10'h302], mem[10'h303], mem[10'h304]} !== 40'h00BE_0000_00) begin
         errors++; $display("FAIL abort_mem: got %h %h %h %h %h required 00 be 00 00 00",
                            mem[10'h300], mem[10'h301], mem[10'h302], mem[10'h303], mem[10'h304]);
      end
   endtask

   task automatic test_reject();
      int en_seen = 0;
      int nlat    = 0;
      logic [31:0] rd = 32'hx;
      logic        er = 1'bx;
      @(negedge clk);
      n_req_addr = 32'h0100_0002; n_req_valid = 1'b1;
      if (n_mem_re || n_mem_we) en_seen++;
      @(posedge clk); #1;
      n_req_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (n_mem_re || n_mem_we) en_seen++;
         if (n_rsp_valid && nlat == 0) begin nlat = k + 1; rd = n_rsp_rdata; er = n_rsp_err; end
         @(posedge clk); #1;
      end
      checks++;
      if (nlat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
         errors++; $display("FAIL reject_rsp: got lat=%0d err=%b rdata=%h required 1/1/0", nlat, er, rd);
      end
      checks++;
      if (en_seen !== 0) begin
         errors++; $display("FAIL reject_no_mem: got %0d enabled cycles required 0", en_seen);
      end
   endtask

   initial begin
      test_reset();
      test_aligned_word();
      test_aligned_sub();
      test_split_word_load();
      test_split_half();
      test_reset_mid_split();
      test_reject();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
